id_hazard_ctrl: RTL and testbench

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl_if.sv | 26 ++
 rtl/id_hazard_ctrl.sv | 97 +++++++++
 tb/tb_id_hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard control bus: decode-stage instruction fields in,
// pipeline enable/flush/bubble controls and stall statistics out.
interface id_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        ex_branch_taken;
  logic        mem_stall;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [15:0] stall_cycles;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken, mem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken, mem_stall,
    output pc_en, ifid_en, ifid_flush, idex_bubble, stall_cycles
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage load-use hazard controller: per-register load scoreboard,
// pipeline freeze/flush/stall arbitration and a saturating stall counter.
module id_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  id_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL
  } act_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [1:0] LAT_INIT   = 2'(LOAD_LAT);

  logic [31:0][1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;
  logic             rs1_used, rs2_used, hazard;
  act_t             act;

  always_comb begin
    rs1_used = !(bus.id_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    rs2_used = bus.id_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    hazard   = bus.id_valid &
               ((rs1_used && (cnt_q[bus.id_rs1] != '0)) ||
                (rs2_used && (cnt_q[bus.id_rs2] != '0)));
  end

  always_comb begin
    if (bus.mem_stall)            act = ACT_FREEZE;
    else if (bus.ex_branch_taken) act = ACT_FLUSH;
    else if (hazard)              act = ACT_STALL;
    else                          act = ACT_NORMAL;
  end

  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    unique case (act)
      ACT_FREEZE: begin
        bus.pc_en   = 1'b0;
        bus.ifid_en = 1'b0;
      end
      ACT_FLUSH: begin
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
      end
      ACT_STALL: begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_bubble = 1'b1;
      end
      default: ;
    endcase
    bus.stall_cycles = stall_q;
  end

  // Decrement first, then let an issuing write to rd override its own entry.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (act != ACT_FREEZE) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 2'd1;
      end
      if (act == ACT_NORMAL && bus.id_valid && bus.id_rd != '0) begin
        cnt_d[bus.id_rd] = (bus.id_opcode == OPC_LOAD) ? LAT_INIT : '0;
      end
    end
    cnt_d[0] = '0;
    if (act == ACT_STALL && stall_q != '1) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: two instances (LOAD_LAT 1 and 3) against a
// timestamp-based readiness model; directed cases then randomized traffic.
module tb_id_hazard_ctrl;

  localparam logic [4:0] LOAD = 5'b00000, OP = 5'b01100, LUI = 5'b01101,
                         AUIPC = 5'b00101, JAL = 5'b11011, STORE = 5'b01000,
                         BRANCH = 5'b11000, IMM = 5'b00100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_opcode = '0, id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       ex_branch_taken = 1'b0, mem_stall = 1'b0;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl_if bus1 ();
  id_hazard_ctrl_if bus3 ();

  assign bus1.id_valid = id_valid;        assign bus3.id_valid = id_valid;
  assign bus1.id_opcode = id_opcode;      assign bus3.id_opcode = id_opcode;
  assign bus1.id_rs1 = id_rs1;            assign bus3.id_rs1 = id_rs1;
  assign bus1.id_rs2 = id_rs2;            assign bus3.id_rs2 = id_rs2;
  assign bus1.id_rd = id_rd;              assign bus3.id_rd = id_rd;
  assign bus1.ex_branch_taken = ex_branch_taken;
  assign bus3.ex_branch_taken = ex_branch_taken;
  assign bus1.mem_stall = mem_stall;      assign bus3.mem_stall = mem_stall;

  id_hazard_ctrl #(.LOAD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  id_hazard_ctrl #(.LOAD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Model: a register is ready once the count of unfrozen cycles reaches ready_at.
  int lat [2] = '{1, 3};
  int tick [2];
  int ready_at [2][32];
  int stalls [2];

  function automatic bit model_hazard(int d);
    bit u1, u2;
    u1 = !(id_opcode == LUI || id_opcode == AUIPC || id_opcode == JAL);
    u2 = (id_opcode == OP || id_opcode == STORE || id_opcode == BRANCH);
    return id_valid &&
           ((u1 && id_rs1 != 0 && tick[d] < ready_at[d][id_rs1]) ||
            (u2 && id_rs2 != 0 && tick[d] < ready_at[d][id_rs2]));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      stalls[d] = 0;
      for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    nvec++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance model at posedge.
  task automatic step(input logic r, input logic v, input logic [4:0] op,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic br, input logic ms, input string tag);
    bit haz [2];
    logic [3:0] want;
    @(negedge clk);
    rst = r; id_valid = v; id_opcode = op; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    ex_branch_taken = br; mem_stall = ms;
    #1;
    for (int k = 0; k < 2; k++) begin
      haz[k] = model_hazard(k);
      if (ms)          want = 4'b0000;
      else if (br)     want = 4'b1111;
      else if (haz[k]) want = 4'b0001;
      else             want = 4'b1100;
      if (k == 0) begin
        check({tag, "/ctl1"}, 16'({bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_bubble}), 16'(want));
        check({tag, "/cnt1"}, bus1.stall_cycles, 16'(stalls[0]));
      end else begin
        check({tag, "/ctl3"}, 16'({bus3.pc_en, bus3.ifid_en, bus3.ifid_flush, bus3.idex_bubble}), 16'(want));
        check({tag, "/cnt3"}, bus3.stall_cycles, 16'(stalls[1]));
      end
    end
    @(posedge clk);
    if (r) model_reset();
    else if (!ms) begin
      for (int k = 0; k < 2; k++) begin
        if (br) ;
        else if (haz[k]) stalls[k] = (stalls[k] < 65535) ? stalls[k] + 1 : 65535;
        else if (v && d != 0) ready_at[k][d] = (op == LOAD) ? tick[k] + 1 + lat[k] : 0;
        tick[k]++;
      end
    end
  endtask

  initial begin
    logic [4:0] ops [8] = '{LOAD, OP, LUI, AUIPC, JAL, STORE, BRANCH, IMM};
    tick = '{0, 0};
    model_reset();
    step(1, 0, IMM, 0, 0, 0, 0, 0, "rst0");
    step(1, 0, IMM, 0, 0, 0, 0, 0, "rst1");
    step(0, 0, IMM, 0, 0, 0, 0, 0, "idle");

    // load-use: lw x5 ; add x6,x5,x1
    step(0, 1, LOAD, 1, 0, 5, 0, 0, "lu_lw");
    step(0, 1, OP,   5, 1, 6, 0, 0, "lu_stall");
    step(0, 1, OP,   5, 1, 6, 0, 0, "lu_retry");
    step(0, 1, OP,   5, 1, 6, 0, 0, "lu_retry2");
    step(0, 1, OP,   5, 1, 6, 0, 0, "lu_retry3");
    step(0, 1, OP,   5, 1, 6, 0, 0, "lu_issue");

    // x0 never stalls
    step(0, 1, LOAD, 1, 0, 0, 0, 0, "x0_lw");
    step(0, 1, OP,   0, 0, 6, 0, 0, "x0_add");

    // newer non-load write clears pending load
    step(0, 1, LOAD, 1, 0, 5, 0, 0, "lui_lw");
    step(0, 1, LUI,  5, 5, 5, 0, 0, "lui_w");
    step(0, 1, OP,   5, 5, 7, 0, 0, "lui_use");

    // branch kills dependent, scoreboard drains
    step(0, 1, LOAD, 1, 0, 5, 0, 0, "br_lw");
    step(0, 1, OP,   5, 1, 6, 1, 0, "br_kill");
    step(0, 1, OP,   5, 1, 6, 0, 0, "br_next");

    // mem_stall freezes everything, stalls resume after release
    step(0, 1, LOAD, 1, 0, 9, 0, 0, "ms_lw");
    for (int i = 0; i < 3; i++) step(0, 1, OP, 9, 1, 6, 0, 1, "ms_frz");
    for (int i = 0; i < 4; i++) step(0, 1, OP, 9, 1, 6, 0, 0, "ms_rel");

    // reset during a hazard cycle
    step(0, 1, LOAD, 1, 0, 5, 0, 0, "rh_lw");
    step(1, 1, OP,   5, 1, 6, 0, 0, "rh_rst");
    step(0, 1, OP,   5, 1, 6, 0, 0, "rh_after");

    // invalid ID still drains counters; rs2 ignored for non-OP users
    step(0, 1, LOAD, 1, 0, 4, 0, 0, "iv_lw");
    step(0, 0, OP,   4, 4, 6, 0, 0, "iv_idle");
    step(0, 1, IMM,  1, 4, 6, 0, 0, "iv_rs2ign");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           ops[$urandom_range(0, 7)],
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
